// File: rtl/gshare_predictor_if.sv
// Fetch/Execute connection bundle for the gshare branch predictor.
// The pipeline side is the master; the predictor itself is the slave.
interface gshare_predictor_if #(
   parameter int GHR_BITS   = 10,
   parameter int INDEX_BITS = 10,
   parameter int CNT_WIDTH  = 32
);
   logic                  stall_F;
   logic                  lookup_en_F;
   logic [31:0]           pc_F;
   logic                  predict_taken_F;
   logic [INDEX_BITS-1:0] predict_index_F;
   logic [GHR_BITS-1:0]   ghr_snapshot_F;
   logic                  update_en_EX;
   logic [INDEX_BITS-1:0] update_index_EX;
   logic [GHR_BITS-1:0]   update_ghr_EX;
   logic                  actual_taken_EX;
   logic                  predicted_taken_EX;
   logic                  mispredict_EX;
   logic [CNT_WIDTH-1:0]  branch_count;
   logic [CNT_WIDTH-1:0]  mispredict_count;

   modport master (
      output stall_F, lookup_en_F, pc_F,
      output update_en_EX, update_index_EX, update_ghr_EX,
      output actual_taken_EX, predicted_taken_EX,
      input  predict_taken_F, predict_index_F, ghr_snapshot_F,
      input  mispredict_EX, branch_count, mispredict_count
   );

   modport slave (
      input  stall_F, lookup_en_F, pc_F,
      input  update_en_EX, update_index_EX, update_ghr_EX,
      input  actual_taken_EX, predicted_taken_EX,
      output predict_taken_F, predict_index_F, ghr_snapshot_F,
      output mispredict_EX, branch_count, mispredict_count
   );
endinterface

// File: rtl/gshare_predictor.sv
// Gshare conditional-branch direction predictor.
// Combinational lookup in Fetch (PC xor global history into a table of
// 2-bit saturating counters), training and history repair from Execute,
// plus branch / mispredict performance counters.
module gshare_predictor #(
   parameter int GHR_BITS   = 10,
   parameter int INDEX_BITS = 10,
   parameter int PC_LSB     = 2,
   parameter int CNT_WIDTH  = 32
) (
   input logic              clk,
   input logic              rst,
   gshare_predictor_if.slave bp
);
   localparam int PHT_ENTRIES = 1 << INDEX_BITS;

   logic [1:0]            pht [PHT_ENTRIES];
   logic [GHR_BITS-1:0]   ghr;
   logic [CNT_WIDTH-1:0]  branch_cnt;
   logic [CNT_WIDTH-1:0]  mispredict_cnt;

   logic [INDEX_BITS-1:0] lookup_index;
   logic                  lookup_taken;
   logic                  mispredict;
   logic [1:0]            cur_cnt;
   logic [1:0]            new_cnt;
   logic                  unused_pc;

   assign unused_pc = ^bp.pc_F;

   // Fetch-side lookup: hash PC with zero-extended history, read the counter MSB.
   always_comb begin
      lookup_index = bp.pc_F[PC_LSB+INDEX_BITS-1:PC_LSB] ^ INDEX_BITS'(ghr);
      lookup_taken = bp.lookup_en_F & pht[lookup_index][1];
   end

   // Execute-side resolution: mispredict flag and the saturated counter value to write back.
   always_comb begin
      mispredict = bp.update_en_EX & (bp.actual_taken_EX != bp.predicted_taken_EX);
      cur_cnt    = pht[bp.update_index_EX];
      new_cnt    = cur_cnt;
      if (bp.actual_taken_EX) begin
         if (cur_cnt != 2'b11) begin
            new_cnt = cur_cnt + 2'b01;
         end
      end else begin
         if (cur_cnt != 2'b00) begin
            new_cnt = cur_cnt - 2'b01;
         end
      end
   end

   // Pattern table training; the lookup above reads the pre-edge value on a same-index collision.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < PHT_ENTRIES; i++) begin
            pht[i] <= 2'b01;
         end
      end else if (bp.update_en_EX) begin
         pht[bp.update_index_EX] <= new_cnt;
      end
   end

   // Global history: restore on mispredict beats a speculative shift from an unstalled lookup.
   always_ff @(posedge clk) begin
      if (!rst) begin
         ghr <= '0;
      end else if (mispredict) begin
         ghr <= {bp.update_ghr_EX[GHR_BITS-2:0], bp.actual_taken_EX};
      end else if (bp.lookup_en_F && !bp.stall_F) begin
         ghr <= {ghr[GHR_BITS-2:0], lookup_taken};
      end
   end

   // Performance counters, free-running and wrapping.
   always_ff @(posedge clk) begin
      if (!rst) begin
         branch_cnt     <= '0;
         mispredict_cnt <= '0;
      end else begin
         if (bp.update_en_EX) begin
            branch_cnt <= branch_cnt + CNT_WIDTH'(1);
         end
         if (mispredict) begin
            mispredict_cnt <= mispredict_cnt + CNT_WIDTH'(1);
         end
      end
   end

   assign bp.predict_taken_F  = lookup_taken;
   assign bp.predict_index_F  = lookup_index;
   assign bp.ghr_snapshot_F   = ghr;
   assign bp.mispredict_EX    = mispredict;
   assign bp.branch_count     = branch_cnt;
   assign bp.mispredict_count = mispredict_cnt;
endmodule

// File: doc/gshare_predictor.md
Name: gshare_predictor

Overview:
Gshare conditional-branch direction predictor for the 5-stage pipelined RV32I core. It is looked up combinationally in Fetch and drives the taken decision into the PC select mux. It is trained from Execute when the branch resolves, and restores global history on a mispredict. It also keeps branch and mispredict counters for performance reporting.

Parameters:
GHR_BITS, 10, width of the global history register (must be <= INDEX_BITS)
INDEX_BITS, 10, log2 of the pattern history table (PHT) entry count
PC_LSB, 2, lowest PC bit used in the index (drops byte offset)
CNT_WIDTH, 32, width of the performance counters

Ports:
clk  input  1  core clock, all state updates on rising edge
rst  input  1  synchronous active-low reset
stall_F  input  1  fetch stall; blocks speculative history update
lookup_en_F  input  1  fetched instruction is a conditional branch
pc_F  input  32  fetch PC
predict_taken_F  output  1  predicted direction, combinational
predict_index_F  output  INDEX_BITS  PHT index used; carried down the pipe to EX
ghr_snapshot_F  output  GHR_BITS  GHR value before this lookup; carried down the pipe to EX
update_en_EX  input  1  resolved conditional branch in EX
update_index_EX  input  INDEX_BITS  predict_index_F of the resolving branch
update_ghr_EX  input  GHR_BITS  ghr_snapshot_F of the resolving branch
actual_taken_EX  input  1  resolved direction
predicted_taken_EX  input  1  direction predicted in fetch for this branch
mispredict_EX  output  1  update_en_EX && (actual_taken_EX != predicted_taken_EX), combinational
branch_count  output  CNT_WIDTH  resolved branches since reset
mispredict_count  output  CNT_WIDTH  mispredicts since reset

Behaviour:
- Index: pc_F[PC_LSB+INDEX_BITS-1:PC_LSB] XOR {zero-pad, ghr}. The GHR is zero-extended in the upper bits when GHR_BITS < INDEX_BITS.
- PHT: 2^INDEX_BITS entries, each a 2-bit saturating counter.
  - 00 = strong not-taken, 01 = weak not-taken, 10 = weak taken, 11 = strong taken.
  - predict_taken_F = PHT[index][1] when lookup_en_F = 1, else 0.
- Lookup latency: 0 cycles (combinational read). predict_index_F and ghr_snapshot_F are always driven, even when lookup_en_F = 0.
- PHT training happens on the clock edge when update_en_EX = 1.
  - Taken: increment, saturating at 11.
  - Not taken: decrement, saturating at 00.
- Same-cycle read and write of the same index: the lookup sees the old value. The write lands at the edge.
- GHR update, one per edge, in this priority order:
  1. mispredict_EX = 1: ghr <= {update_ghr_EX[GHR_BITS-2:0], actual_taken_EX}. This is a restore; any same-cycle lookup is discarded (fetch is being flushed).
  2. Otherwise, lookup_en_F && !stall_F: ghr <= {ghr[GHR_BITS-2:0], predict_taken_F} (speculative).
  3. Otherwise: hold.
- A correctly predicted update does not modify the GHR, because the speculative value is already correct.
- Counters:
  - branch_count increments on every update_en_EX.
  - mispredict_count increments on every mispredict_EX.
  - Both wrap modulo 2^CNT_WIDTH.
- Reset: while rst = 0 at a rising edge:
  - ghr <= 0.
  - Every PHT entry <= 01.
  - branch_count and mispredict_count <= 0.
  - Reset overrides any same-cycle update or lookup.
  - Reset asserted mid-operation discards all history.
- Outputs during and just after reset:
  - predict_taken_F = 0 for any lookup (all entries are 01).
  - ghr_snapshot_F = 0.
  - predict_index_F equals the PC bits alone.
- Stall: with stall_F = 1, lookups still drive outputs, but the GHR does not shift. EX updates and PHT writes proceed regardless of stall.
- update_en_EX = 0: no PHT, GHR (restore) or counter change from the EX side; mispredict_EX = 0.

Test Plan:
1. Reset check: hold rst = 0 for 2 cycles, then lookup pc_F = 0x100 -> predict_taken_F = 0, predict_index_F = 0x040, ghr_snapshot_F = 0, both counters = 0.
2. Saturation: issue 3 taken updates at index 0x040 -> the entry walks 01 -> 10 -> 11 -> 11. The next lookup with index 0x040 predicts 1. Then 4 not-taken updates -> the entry reaches 00 and stays there.
3. Speculative history: from GHR = 0, two consecutive lookups predicted 1 with stall_F = 0 -> GHR = 0x003. Repeat with stall_F = 1 -> GHR unchanged.
4. Mispredict restore: GHR = 0x3FF, update_ghr_EX = 0x155, actual = 0, predicted = 1, with a simultaneous lookup -> mispredict_EX = 1, next GHR = 0x2AA (restore wins over the lookup), mispredict_count += 1.
5. Same-index collision: lookup and update at index 0x012 with entry = 01 and taken -> predict_taken_F = 0 this cycle, 1 the next cycle.
6. Counter wrap: force branch_count to 0xFFFFFFFF, apply one update -> branch_count = 0. Then drive rst = 0 mid-stream with update_en_EX = 1 -> all counters = 0 and the PHT entry = 01.
